// File: rtl/osc_bank_sampler.sv
// osc_bank_sampler: gated measurement controller for a ring-oscillator bank.
// A START clears the bank, runs it for WINDOW cycles and waits SETTLE_CYCLES
// for the counts to freeze. It then walks the channels one per cycle to
// produce SUM, MAX and MAX_INDEX, and finally pulses DONE.
// Optional feature macro: OSC_BANK_SAMPLER_CHANNEL_STORE_EN adds a
// per-channel register file that is read back via CH_SEL / CH_COUNT.
// Handshake: START is a request that is taken only while idle (BUSY=0).
// DONE is a one-cycle valid pulse for SUM/MAX/MAX_INDEX. There is no
// back-pressure. ABORT cancels any non-idle state without producing a DONE.
module osc_bank_sampler #(
  parameter int COUNTER_LENGTH = 16,
  parameter int BANK_SIZE      = 16,
  parameter int WINDOW_LENGTH  = 20,
  parameter int SETTLE_CYCLES  = 4,
  localparam int SUM_LENGTH    = COUNTER_LENGTH + $clog2(BANK_SIZE),
  localparam int IDX_LENGTH    = $clog2(BANK_SIZE)
) (
  input  logic                                CLOCK,
  input  logic                                RESET,
  input  logic                                START,
  input  logic                                ABORT,
  input  logic [WINDOW_LENGTH-1:0]            WINDOW,
  input  logic [BANK_SIZE*COUNTER_LENGTH-1:0] OSC_COUNT,
  output logic                                OSC_CLEAR,
  output logic                                OSC_RUN,
  output logic                                BUSY,
  output logic                                DONE,
  output logic [SUM_LENGTH-1:0]               SUM,
  output logic [COUNTER_LENGTH-1:0]           MAX,
  output logic [IDX_LENGTH-1:0]               MAX_INDEX,
  input  logic [IDX_LENGTH-1:0]               CH_SEL,
  output logic [COUNTER_LENGTH-1:0]           CH_COUNT
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_RUN, ST_SETTLE, ST_ACCUM, ST_DONE
  } state_t;

  // state_q is the observable FSM state for checkers
  state_t                    state_q, state_d;
  logic [WINDOW_LENGTH-1:0]  win_cnt_q;
  logic [SETTLE_W-1:0]       settle_cnt_q;
  logic [IDX_LENGTH-1:0]     ch_idx_q;
  logic [SUM_LENGTH-1:0]     shadow_sum_q;
  logic [COUNTER_LENGTH-1:0] shadow_max_q;
  logic [IDX_LENGTH-1:0]     shadow_idx_q;

  logic [COUNTER_LENGTH-1:0] ch_val;
  logic [SUM_LENGTH-1:0]     sum_d;
  logic [COUNTER_LENGTH-1:0] max_d;
  logic [IDX_LENGTH-1:0]     idx_d;
  logic                      last_ch;
  logic                      commit;

  // Current channel and the running sum/max including it
  always_comb begin
    ch_val  = OSC_COUNT[int'(ch_idx_q)*COUNTER_LENGTH +: COUNTER_LENGTH];
    sum_d   = shadow_sum_q + SUM_LENGTH'(ch_val);
    max_d   = shadow_max_q;
    idx_d   = shadow_idx_q;
    if (ch_val > shadow_max_q) begin
      max_d = ch_val;
      idx_d = ch_idx_q;
    end
    last_ch = (ch_idx_q == IDX_LENGTH'(BANK_SIZE - 1));
  end

  // Next-state logic; ABORT overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (START) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_RUN;
      ST_RUN:    if (win_cnt_q == WINDOW_LENGTH'(1)) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_q == SETTLE_W'(1)) state_d = ST_ACCUM;
      ST_ACCUM:  if (last_ch) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (ABORT && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Results are published on the edge that enters DONE (never after ABORT)
  assign commit = (state_q == ST_ACCUM) && (state_d == ST_DONE);

  // State, counters, shadow accumulators and registered outputs
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      ch_idx_q     <= '0;
      shadow_sum_q <= '0;
      shadow_max_q <= '0;
      shadow_idx_q <= '0;
      OSC_CLEAR    <= 1'b0;
      OSC_RUN      <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      SUM          <= '0;
      MAX          <= '0;
      MAX_INDEX    <= '0;
    end else begin
      state_q   <= state_d;
      OSC_CLEAR <= (state_d == ST_CLEAR);
      OSC_RUN   <= (state_d == ST_RUN);
      BUSY      <= (state_d != ST_IDLE);
      DONE      <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          // A zero window still runs the bank for one cycle
          if (START) win_cnt_q <= (WINDOW == '0) ? WINDOW_LENGTH'(1) : WINDOW;
        end
        ST_RUN: begin
          win_cnt_q    <= win_cnt_q - WINDOW_LENGTH'(1);
          settle_cnt_q <= SETTLE_W'(SETTLE_CYCLES);
        end
        ST_SETTLE: begin
          settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
          ch_idx_q     <= '0;
          shadow_sum_q <= '0;
          shadow_max_q <= '0;
          shadow_idx_q <= '0;
        end
        ST_ACCUM: begin
          ch_idx_q     <= ch_idx_q + IDX_LENGTH'(1);
          shadow_sum_q <= sum_d;
          shadow_max_q <= max_d;
          shadow_idx_q <= idx_d;
        end
        default: ;
      endcase
      if (commit) begin
        SUM       <= sum_d;
        MAX       <= max_d;
        MAX_INDEX <= idx_d;
      end
    end
  end

`ifdef OSC_BANK_SAMPLER_CHANNEL_STORE_EN
  logic [COUNTER_LENGTH-1:0] shadow_store_q [BANK_SIZE];
  logic [COUNTER_LENGTH-1:0] store_q        [BANK_SIZE];

  // Capture channels during ACCUM, publish the full file with SUM, read back
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < BANK_SIZE; i++) begin
        shadow_store_q[i] <= '0;
        store_q[i]        <= '0;
      end
      CH_COUNT <= '0;
    end else begin
      if (state_q == ST_ACCUM) shadow_store_q[ch_idx_q] <= ch_val;
      if (commit) begin
        for (int i = 0; i < BANK_SIZE; i++) begin
          store_q[i] <= (i == BANK_SIZE - 1) ? ch_val : shadow_store_q[i];
        end
      end
      CH_COUNT <= (int'(CH_SEL) < BANK_SIZE) ? store_q[CH_SEL] : '0;
    end
  end
`else
  // No channel store: readback is constant zero. CH_SEL is masked to zero
  // here only so the input is consumed.
  assign CH_COUNT = {COUNTER_LENGTH{1'b0}} & {COUNTER_LENGTH{^CH_SEL}};
`endif

endmodule

// File: tb/tb_osc_bank_sampler.sv
// Testbench for osc_bank_sampler (BANK_SIZE=4, SETTLE_CYCLES=4).
// The bank model clears on OSC_CLEAR and adds a per-channel rate on every
// cycle in which OSC_RUN is high, so frozen counts equal rate * window.
module tb_osc_bank_sampler;

  localparam int CL = 16;
  localparam int BS = 4;
  localparam int WL = 20;
  localparam int SL = CL + 2;

  logic              CLOCK = 1'b0;
  logic              RESET = 1'b1;
  logic              START = 1'b0;
  logic              ABORT = 1'b0;
  logic [WL-1:0]     WINDOW = '0;
  logic [BS*CL-1:0]  OSC_COUNT;
  logic              OSC_CLEAR, OSC_RUN, BUSY, DONE;
  logic [SL-1:0]     SUM;
  logic [CL-1:0]     MAX;
  logic [1:0]        MAX_INDEX;
  logic [1:0]        CH_SEL = '0;
  logic [CL-1:0]     CH_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  osc_bank_sampler #(
    .COUNTER_LENGTH(CL), .BANK_SIZE(BS), .WINDOW_LENGTH(WL), .SETTLE_CYCLES(4)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .WINDOW(WINDOW), .OSC_COUNT(OSC_COUNT), .OSC_CLEAR(OSC_CLEAR),
    .OSC_RUN(OSC_RUN), .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .MAX(MAX),
    .MAX_INDEX(MAX_INDEX), .CH_SEL(CH_SEL), .CH_COUNT(CH_COUNT)
  );

  // clock
  always #5 CLOCK = ~CLOCK;

  // bank model
  logic [CL-1:0] rate   [BS];
  logic [CL-1:0] bank_q [BS];
  initial for (int i = 0; i < BS; i++) begin rate[i] = '0; bank_q[i] = '0; end
  always @(posedge CLOCK) begin
    for (int i = 0; i < BS; i++) begin
      if (OSC_CLEAR) bank_q[i] <= '0;
      else if (OSC_RUN) bank_q[i] <= bank_q[i] + rate[i];
    end
  end
  always_comb for (int i = 0; i < BS; i++) OSC_COUNT[i*CL +: CL] = bank_q[i];

  typedef struct {
    logic [WL-1:0] window;
    logic [CL-1:0] rate [BS];
    int            exp_lat;
    logic [SL-1:0] exp_sum;
    logic [CL-1:0] exp_max;
    logic [1:0]    exp_idx;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // watch from the negedge after START's edge (k=0) until DONE, bounded
  task automatic watch_done(output int lat, output int runs, output int clrs,
                            output int first_clr, output int first_run);
    lat = -1; runs = 0; clrs = 0; first_clr = -1; first_run = -1;
    for (int k = 0; k < 3000; k++) begin
      if (OSC_CLEAR) begin clrs++; if (first_clr < 0) first_clr = k; end
      if (OSC_RUN) begin runs++; if (first_run < 0) first_run = k; end
      if (DONE) begin lat = k; break; end
      @(negedge CLOCK);
    end
  endtask

  task automatic start_req(input logic [WL-1:0] w);
    @(negedge CLOCK);
    START = 1'b1; WINDOW = w;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic check_ch(input string name, input int ch, input logic [CL-1:0] stored);
    @(negedge CLOCK);
    CH_SEL = 2'(ch);
    @(negedge CLOCK);
`ifdef OSC_BANK_SAMPLER_CHANNEL_STORE_EN
    check(name, CH_COUNT, stored);
`else
    check(name, CH_COUNT, 0 * stored);
`endif
  endtask

  task automatic set_rates(input int r0, input int r1, input int r2, input int r3);
    rate[0] = CL'(r0); rate[1] = CL'(r1); rate[2] = CL'(r2); rate[3] = CL'(r3);
  endtask

  initial begin
    int lat, runs, clrs, fc, fr, ndone, weff;

    vecs[0].window = 10; vecs[0].rate = '{10, 20, 30, 5};
    vecs[0].exp_lat = 19; vecs[0].exp_sum = 650; vecs[0].exp_max = 300; vecs[0].exp_idx = 2;
    vecs[1].window = 5;  vecs[1].rate = '{13107, 13107, 13107, 13107};
    vecs[1].exp_lat = 14; vecs[1].exp_sum = 262140; vecs[1].exp_max = 65535; vecs[1].exp_idx = 0;
    vecs[2].window = 0;  vecs[2].rate = '{3, 7, 7, 2};
    vecs[2].exp_lat = 10; vecs[2].exp_sum = 19; vecs[2].exp_max = 7; vecs[2].exp_idx = 1;
    vecs[3].window = 2;  vecs[3].rate = '{0, 0, 0, 0};
    vecs[3].exp_lat = 11; vecs[3].exp_sum = 0; vecs[3].exp_max = 0; vecs[3].exp_idx = 0;
    vecs[4].window = 3;  vecs[4].rate = '{1, 2, 3, 40};
    vecs[4].exp_lat = 12; vecs[4].exp_sum = 138; vecs[4].exp_max = 120; vecs[4].exp_idx = 3;

    // reset state
    #1;
    check("rst OSC_CLEAR", OSC_CLEAR, 0);
    check("rst OSC_RUN", OSC_RUN, 0);
    check("rst BUSY", BUSY, 0);
    check("rst DONE", DONE, 0);
    check("rst SUM", SUM, 0);
    check("rst MAX", MAX, 0);
    check("rst MAX_INDEX", MAX_INDEX, 0);
    check("rst CH_COUNT", CH_COUNT, 0);
    @(negedge CLOCK); @(negedge CLOCK);
    RESET = 1'b0;

    // table-driven measurements
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < BS; i++) rate[i] = vecs[v].rate[i];
      weff = (vecs[v].window == 0) ? 1 : int'(vecs[v].window);
      start_req(vecs[v].window);
      watch_done(lat, runs, clrs, fc, fr);
      check($sformatf("v%0d latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d SUM", v), SUM, vecs[v].exp_sum);
      check($sformatf("v%0d MAX", v), MAX, vecs[v].exp_max);
      check($sformatf("v%0d MAX_INDEX", v), MAX_INDEX, vecs[v].exp_idx);
      check($sformatf("v%0d run cycles", v), runs, weff);
      check($sformatf("v%0d clear cycles", v), clrs, 1);
      check($sformatf("v%0d clear pos", v), fc, 0);
      check($sformatf("v%0d run pos", v), fr, 1);
      @(negedge CLOCK);
      check($sformatf("v%0d DONE pulse", v), DONE, 0);
      check($sformatf("v%0d BUSY after", v), BUSY, 0);
      for (int i = 0; i < BS; i++)
        check_ch($sformatf("v%0d CH_COUNT[%0d]", v, i), i, CL'(int'(vecs[v].rate[i]) * weff));
      check($sformatf("v%0d SUM hold", v), SUM, vecs[v].exp_sum);
    end

    // back-to-back: START held high through DONE
    set_rates(10, 20, 30, 5);
    @(negedge CLOCK);
    START = 1'b1; WINDOW = 10;
    @(negedge CLOCK);
    watch_done(lat, runs, clrs, fc, fr);
    check("b2b first latency", lat, 19);
    check("b2b first SUM", SUM, 650);
    @(negedge CLOCK);
    check("b2b idle gap BUSY", BUSY, 0);
    @(negedge CLOCK);
    check("b2b restart BUSY", BUSY, 1);
    check("b2b restart CLEAR", OSC_CLEAR, 1);
    START = 1'b0;
    watch_done(lat, runs, clrs, fc, fr);
    check("b2b second latency", lat, 19);
    check("b2b second SUM", SUM, 650);

    // abort on the 5th RUN cycle
    start_req(10);
    for (int k = 0; k < 5; k++) @(negedge CLOCK);
    check("abort pre OSC_RUN", OSC_RUN, 1);
    ABORT = 1'b1;
    @(negedge CLOCK);
    ABORT = 1'b0;
    check("abort BUSY", BUSY, 0);
    check("abort OSC_RUN", OSC_RUN, 0);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (DONE) ndone++;
      @(negedge CLOCK);
    end
    check("abort no DONE", ndone, 0);
    check("abort SUM kept", SUM, 650);
    check("abort MAX kept", MAX, 300);
    check("abort MAX_INDEX kept", MAX_INDEX, 2);
    check_ch("abort CH_COUNT[1]", 1, 200);
    set_rates(1, 1, 1, 1);
    start_req(4);
    watch_done(lat, runs, clrs, fc, fr);
    check("post-abort latency", lat, 13);
    check("post-abort SUM", SUM, 16);
    check("post-abort MAX", MAX, 4);
    check("post-abort MAX_INDEX", MAX_INDEX, 0);

    // asynchronous reset during ACCUM
    set_rates(2, 9, 4, 1);
    start_req(2);
    for (int k = 0; k < 8; k++) @(negedge CLOCK);
    check("pre-reset BUSY", BUSY, 1);
    RESET = 1'b1; START = 1'b1; WINDOW = 2;
    #1;
    check("async BUSY", BUSY, 0);
    check("async DONE", DONE, 0);
    check("async OSC_RUN", OSC_RUN, 0);
    check("async OSC_CLEAR", OSC_CLEAR, 0);
    check("async SUM", SUM, 0);
    check("async MAX", MAX, 0);
    check("async MAX_INDEX", MAX_INDEX, 0);
    check("async CH_COUNT", CH_COUNT, 0);
    @(negedge CLOCK); @(negedge CLOCK);
    check("START in reset", BUSY, 0);
    RESET = 1'b0;
    @(negedge CLOCK);
    check("post-reset accept", BUSY, 1);
    START = 1'b0;
    watch_done(lat, runs, clrs, fc, fr);
    check("post-reset latency", lat, 11);
    check("post-reset SUM", SUM, 32);
    check("post-reset MAX", MAX, 18);
    check("post-reset MAX_INDEX", MAX_INDEX, 1);
    check_ch("post-reset CH_COUNT[2]", 2, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
